// File: rtl/lcd_write_sequencer.sv
// HD44780-style LCD write sequencer.
// Turns each GO-bit toggle in the LCD buffer register into a timed parallel
// write: setup, EN pulse, hold, then an execution wait. One request can
// queue behind the active transfer. Further requests are dropped, and a
// sticky overflow flag records the drop.
module lcd_write_sequencer #(
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 13,
    parameter int HOLD_CYC      = 1,
    parameter int WAIT_CYC      = 2000,
    parameter int LONG_WAIT_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_busy,
    output logic        o_lcd_ovf
);

    // The counter must hold the largest phase length.
    localparam int M0   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int M1   = (M0 > HOLD_CYC) ? M0 : HOLD_CYC;
    localparam int M2   = (M1 > WAIT_CYC) ? M1 : WAIT_CYC;
    localparam int MAXP = (M2 > LONG_WAIT_CYC) ? M2 : LONG_WAIT_CYC;
    localparam int CW   = $clog2(MAXP + 1);

    // Each phase ends on the cycle where the counter reaches its last value.
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] LWAIT_LAST = CW'(LONG_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ENABLE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_go_q;
    logic            r_on;
    logic [7:0]      r_data;
    logic            r_rs;
    logic            r_en;
    logic            r_busy;
    logic            r_ovf;
    logic            r_long;
    logic            r_pend_vld;
    logic [7:0]      r_pend_data;
    logic            r_pend_rs;
    logic            r_pend_long;

    logic            w_req;
    logic [7:0]      w_pay_data;
    logic            w_pay_rs;
    logic            w_pay_long;
    logic            w_last_wait;
    logic            w_unused_bits;

    // Clear/home commands (RS=0, data 0x01..0x03) need the long execution wait.
    function automatic logic is_long(input logic rs, input logic [7:0] d);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    assign w_req       = i_lcd_reg[10] ^ r_go_q;
    assign w_pay_data  = i_lcd_reg[7:0];
    assign w_pay_rs    = i_lcd_reg[8];
    assign w_pay_long  = is_long(w_pay_rs, w_pay_data);
    assign w_last_wait = (r_state == S_WAIT) &&
                         (r_cnt == (r_long ? LWAIT_LAST : WAIT_LAST));
    assign w_unused_bits = ^{i_lcd_reg[30:11], i_lcd_reg[9]};

    assign o_lcd_data = r_data;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_en;
    assign o_lcd_on   = r_on;
    assign o_lcd_busy = r_busy;
    assign o_lcd_ovf  = r_ovf;

    // GO edge detector and ON passthrough, both independent of the FSM.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_go_q <= 1'b0;
            r_on   <= 1'b0;
        end else begin
            r_go_q <= i_lcd_reg[10];
            r_on   <= i_lcd_reg[31];
        end
    end

    // Write-cycle FSM with a one-deep pending slot and a sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
            r_long      <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_data <= 8'h00;
            r_pend_rs   <= 1'b0;
            r_pend_long <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        r_data  <= w_pay_data;
                        r_rs    <= w_pay_rs;
                        r_long  <= w_pay_long;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                        r_state <= S_ENABLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ENABLE: begin
                    if (r_cnt == EN_LAST) begin
                        r_cnt   <= '0;
                        r_en    <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_last_wait) begin
                        r_cnt <= '0;
                        if (r_pend_vld) begin
                            // The queued request goes first. A request
                            // arriving this cycle refills the slot it frees.
                            r_data     <= r_pend_data;
                            r_rs       <= r_pend_rs;
                            r_long     <= r_pend_long;
                            r_pend_vld <= w_req;
                            if (w_req) begin
                                r_pend_data <= w_pay_data;
                                r_pend_rs   <= w_pay_rs;
                                r_pend_long <= w_pay_long;
                            end
                            r_state <= S_SETUP;
                        end else if (w_req) begin
                            r_data  <= w_pay_data;
                            r_rs    <= w_pay_rs;
                            r_long  <= w_pay_long;
                            r_state <= S_SETUP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            // A request that cannot launch this cycle is queued, or dropped
            // if the slot is already occupied.
            if (w_req && r_state != S_IDLE && !w_last_wait) begin
                if (!r_pend_vld) begin
                    r_pend_vld  <= 1'b1;
                    r_pend_data <= w_pay_data;
                    r_pend_rs   <= w_pay_rs;
                    r_pend_long <= w_pay_long;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Self-checking bench for lcd_write_sequencer. Wait lengths are shortened so
// the long-command case fits in a short run.
module tb_lcd_write_sequencer;

    localparam int S  = 2;
    localparam int E  = 13;
    localparam int H  = 1;
    localparam int W  = 40;
    localparam int LW = 120;
    localparam int T  = S + E + H + W;
    localparam int LT = S + E + H + LW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lcd_reg = 32'h0;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_busy, lcd_ovf;

    lcd_write_sequencer #(
        .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
        .WAIT_CYC(W), .LONG_WAIT_CYC(LW)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_lcd_reg(lcd_reg),
        .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
        .o_lcd_en(lcd_en), .o_lcd_on(lcd_on), .o_lcd_busy(lcd_busy),
        .o_lcd_ovf(lcd_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] reg_val;
        logic [7:0]  exp_data;
        logic        exp_rs;
        logic        exp_on;
        int          exp_busy;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         en_rises = 0;
    int         en_len = 0;
    int         hold_left = 0;
    int         busy_run = 0;
    int         last_run = 0;
    logic       prev_en = 1'b0;
    logic       stable_bad = 1'b0;
    logic [8:0] cap = 9'h0;
    logic [8:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard and pulse monitor: each EN rise pops the expected {rs,data}.
    // It also checks pulse width, bus stability during EN and hold, and the
    // length of each continuous busy run.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0; en_len = 0; hold_left = 0; busy_run = 0; stable_bad = 1'b0;
        end else begin
            if (lcd_en && !prev_en) begin
                en_rises++;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    chk("sb_rs_data", 32'({lcd_rs, lcd_data}), 32'(sb_q.pop_front()));
                end
                cap = {lcd_rs, lcd_data};
                en_len = 1;
                stable_bad = 1'b0;
            end else if (lcd_en) begin
                en_len++;
                if ({lcd_rs, lcd_data} !== cap) stable_bad = 1'b1;
            end else if (prev_en) begin
                chk("en_width", 32'(en_len), 32'(E));
                hold_left = H;
            end
            if (!lcd_en && hold_left > 0) begin
                if ({lcd_rs, lcd_data} !== cap) stable_bad = 1'b1;
                hold_left--;
                if (hold_left == 0) chk("bus_stable", 32'(stable_bad), 32'd0);
            end
            prev_en = lcd_en;
            if (lcd_busy) busy_run++;
            else if (busy_run > 0) begin
                last_run = busy_run;
                busy_run = 0;
            end
        end
    end

    task automatic drive(input int n, input logic [31:0] v);
        repeat (n) @(posedge clk);
        #1 lcd_reg = v;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (lcd_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(lcd_busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 0;
        int first_en = -1;
        sb_q.push_back({v.exp_rs, v.exp_data});
        drive(1, v.reg_val);
        @(posedge clk);
        @(negedge clk);
        chk("vec_on", 32'(lcd_on), 32'(v.exp_on));
        chk("vec_launch", 32'({lcd_busy, lcd_en, lcd_rs, lcd_data}),
            32'({1'b1, 1'b0, v.exp_rs, v.exp_data}));
        while (lcd_busy && cyc < LT + 20) begin
            if (lcd_en && first_en < 0) first_en = cyc;
            cyc++;
            @(negedge clk);
        end
        chk("vec_en_start", 32'(first_en), 32'(S));
        chk("vec_busy_len", 32'(cyc), 32'(v.exp_busy));
    endtask

    vec_t vecs[8];

    initial begin
        int   r0;
        logic bad;

        vecs[0] = '{32'h8000_0438, 8'h38, 1'b0, 1'b1, T};
        vecs[1] = '{32'h8000_0001, 8'h01, 1'b0, 1'b1, LT};
        vecs[2] = '{32'h0000_0502, 8'h02, 1'b1, 1'b0, T};
        vecs[3] = '{32'h8000_0003, 8'h03, 1'b0, 1'b1, LT};
        vecs[4] = '{32'h0000_0404, 8'h04, 1'b0, 1'b0, T};
        vecs[5] = '{32'h8000_01FF, 8'hFF, 1'b1, 1'b1, T};
        vecs[6] = '{32'h8000_0402, 8'h02, 1'b0, 1'b1, LT};
        vecs[7] = '{32'h8FF0_0A00, 8'h00, 1'b0, 1'b1, T};

        // Reset held for 100 cycles: every output stays low.
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if ({lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_busy, lcd_ovf} !== 14'h0) bad = 1'b1;
        end
        chk("reset_outputs", 32'(bad), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset", 32'({lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_busy, lcd_ovf}), 32'd0);
        chk("no_en_in_reset", 32'(en_rises), 32'd0);

        // Isolated requests, including long-wait commands and ignored bits.
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        chk("rw_low", 32'(lcd_rw), 32'd0);
        chk("no_ovf_isolated", 32'(lcd_ovf), 32'd0);

        // Three toggles 10 cycles apart: the third overflows and is dropped.
        r0 = en_rises;
        sb_q.push_back(9'h141);
        sb_q.push_back(9'h142);
        drive(1, 32'h0000_0541);
        drive(10, 32'h0000_0142);
        drive(10, 32'h0000_0543);
        @(posedge clk);
        @(negedge clk);
        chk("ovf_set", 32'(lcd_ovf), 32'd1);
        wait_idle(4 * T);
        chk("ovf_pulses", 32'(en_rises - r0), 32'd2);
        chk("ovf_back2back", 32'(last_run), 32'(2 * T));
        chk("ovf_sticky", 32'(lcd_ovf), 32'd1);

        // Asynchronous reset in the middle of the EN pulse.
        sb_q.push_back(9'h033);
        drive(1, 32'h8000_0033);
        repeat (S + 3) @(posedge clk);
        #2 chk("en_before_reset", 32'(lcd_en), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 32'({lcd_data, lcd_rs, lcd_en, lcd_on, lcd_busy, lcd_ovf}), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        r0 = en_rises;
        bad = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            if (lcd_busy || lcd_en) bad = 1'b1;
        end
        chk("quiet_after_reset", 32'(bad), 32'd0);
        chk("no_pulse_after_reset", 32'(en_rises - r0), 32'd0);

        // Pending slot full and a new toggle on the last WAIT cycle: no drop.
        r0 = en_rises;
        sb_q.push_back(9'h161);
        sb_q.push_back(9'h162);
        sb_q.push_back(9'h163);
        drive(1, 32'h0000_0561);
        drive(5, 32'h0000_0162);
        drive(T - 5, 32'h0000_0563);
        @(posedge clk);
        @(negedge clk);
        chk("edge_no_ovf_now", 32'(lcd_ovf), 32'd0);
        wait_idle(4 * T);
        chk("edge_pulses", 32'(en_rises - r0), 32'd3);
        chk("edge_back2back", 32'(last_run), 32'(3 * T));
        chk("edge_no_ovf", 32'(lcd_ovf), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
